// File: rtl/instruction_fetch_unit_if.sv
// Bundles the instruction-memory port and the issue/redirect signals exchanged
// between the fetch unit and its neighbours. Direction suffixes are from the
// fetch unit's point of view.
interface instruction_fetch_unit_if;
  // instruction memory side
  logic        imem_read_o;
  logic [31:0] imem_address_o;
  logic [31:0] imem_readdata_i;
  logic        imem_busywait_i;
  // downstream (control unit / datapath) side
  logic        stall_i;
  logic        branch_taken_i;
  logic [7:0]  branch_offset_i;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic [7:0]  opcode_o;
  logic [7:0]  dest_o;
  logic [7:0]  src1_o;
  logic [7:0]  src2_imm_o;

  // fetch unit
  modport master (
    output imem_read_o, imem_address_o, pc_o, instr_valid_o,
           opcode_o, dest_o, src1_o, src2_imm_o,
    input  imem_readdata_i, imem_busywait_i, stall_i,
           branch_taken_i, branch_offset_i
  );

  // memory and downstream logic
  modport slave (
    input  imem_read_o, imem_address_o, pc_o, instr_valid_o,
           opcode_o, dest_o, src1_o, src2_imm_o,
    output imem_readdata_i, imem_busywait_i, stall_i,
           branch_taken_i, branch_offset_i
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Three-state instruction fetch unit: IDLE -> FETCH -> ISSUE -> FETCH ...
// FETCH waits out memory busywait, latches the word into IR and bumps PC by 4.
// ISSUE presents the IR fields until downstream accepts, optionally applying a
// PC-relative word branch measured from the already-incremented PC.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                     clk,
  input logic                     rst_n,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] branch_delta;

  // Signed word offset scaled to bytes; arithmetic wraps modulo 2^32.
  assign branch_delta = {{22{bus.branch_offset_i[7]}}, bus.branch_offset_i, 2'b00};

  // Next-state logic; branch inputs only matter in ISSUE with no stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (!bus.imem_busywait_i) begin
          ir_d    = bus.imem_readdata_i;
          pc_d    = pc_q + 32'd4;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.stall_i) begin
          if (bus.branch_taken_i) begin
            pc_d = pc_q + branch_delta;
          end
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight fetch or issue at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Handshake outputs decode registered state only, so no input reaches them.
  assign bus.imem_read_o    = (state_q == FETCH);
  assign bus.instr_valid_o  = (state_q == ISSUE);
  assign bus.imem_address_o = pc_q;
  assign bus.pc_o           = pc_q;
  assign bus.opcode_o       = ir_q[31:24];
  assign bus.dest_o         = ir_q[23:16];
  assign bus.src1_o         = ir_q[15:8];
  assign bus.src2_imm_o     = ir_q[7:0];

endmodule
